// File: rtl/divider_op_sequencer_if.sv
// Handshake bundle between the operand/result streams, the divider and the sequencer.
`timescale 1ns/1ps
interface divider_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] div_a;
  logic             div_a_stb;
  logic             div_a_ack;
  logic [WIDTH-1:0] div_b;
  logic             div_b_stb;
  logic             div_b_ack;
  logic [WIDTH-1:0] div_z;
  logic             div_z_stb;
  logic             div_z_ack;
  logic [WIDTH-1:0] out_z;
  logic             out_valid;
  logic             out_ready;

  // master is the sequencer, slave is everything around it
  modport master (
    input  in_a, in_b, in_valid,
    output in_ready,
    output div_a, div_a_stb,
    input  div_a_ack,
    output div_b, div_b_stb,
    input  div_b_ack,
    input  div_z, div_z_stb,
    output div_z_ack,
    output out_z, out_valid,
    input  out_ready
  );

  modport slave (
    output in_a, in_b, in_valid,
    input  in_ready,
    input  div_a, div_a_stb,
    output div_a_ack,
    input  div_b, div_b_stb,
    output div_b_ack,
    output div_z, div_z_stb,
    input  div_z_ack,
    input  out_z, out_valid,
    output out_ready
  );
endinterface

// File: rtl/divider_op_sequencer.sv
// Drives one operand pair at a time into the stb/ack divider and queues the
// quotients in a small FIFO for a valid/ready consumer.
`timescale 1ns/1ps
module divider_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  divider_op_sequencer_if.master   bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] div_a_reg, div_a_next;
  logic [WIDTH-1:0] div_b_reg, div_b_next;
  logic             a_stb_reg, a_stb_next;
  logic             b_stb_reg, b_stb_next;
  logic             z_ack_reg, z_ack_next;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;

  logic accept, push, pop, in_ready_w, out_valid_w;

  assign in_ready_w  = rst && (state_reg == IDLE) && (count_reg < CW'(DEPTH));
  assign out_valid_w = rst && (count_reg != '0);
  assign accept      = bus.in_valid && in_ready_w;
  // Room is guaranteed: acceptance required count < DEPTH and only one op is in flight
  assign push        = (state_reg == WAIT_Z) && bus.div_z_stb;
  assign pop         = out_valid_w && bus.out_ready;

  always_comb begin
    state_next = state_reg;
    div_a_next = div_a_reg;
    div_b_next = div_b_reg;
    a_stb_next = a_stb_reg;
    b_stb_next = b_stb_reg;
    z_ack_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          div_a_next = bus.in_a;
          div_b_next = bus.in_b;
          a_stb_next = 1'b1;
          state_next = SEND_A;
        end
      end
      SEND_A: begin
        if (a_stb_reg && bus.div_a_ack) begin
          a_stb_next = 1'b0;
          b_stb_next = 1'b1;
          state_next = SEND_B;
        end
      end
      SEND_B: begin
        if (b_stb_reg && bus.div_b_ack) begin
          b_stb_next = 1'b0;
          state_next = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (bus.div_z_stb) begin
          z_ack_next = 1'b1;
          state_next = ACK_Z;
        end
      end
      ACK_Z:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      div_a_reg  <= '0;
      div_b_reg  <= '0;
      a_stb_reg  <= 1'b0;
      b_stb_reg  <= 1'b0;
      z_ack_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      div_a_reg  <= div_a_next;
      div_b_reg  <= div_b_next;
      a_stb_reg  <= a_stb_next;
      b_stb_reg  <= b_stb_next;
      z_ack_reg  <= z_ack_next;
      count_reg  <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr_reg] <= bus.div_z;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.div_a     = div_a_reg;
  assign bus.div_b     = div_b_reg;
  assign bus.div_a_stb = a_stb_reg;
  assign bus.div_b_stb = b_stb_reg;
  assign bus.div_z_ack = z_ack_reg;
  assign bus.out_valid = out_valid_w;
  assign bus.out_z     = out_valid_w ? mem[rd_ptr_reg] : '0;
  assign busy          = (state_reg != IDLE);
  assign count         = count_reg;
endmodule

// File: tb/tb_divider_op_sequencer.sv
// Bench for divider_op_sequencer: a stub divider with configurable ack delays and
// latency, table-driven single operations and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_divider_op_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic [$clog2(DEPTH):0] count;

  divider_op_sequencer_if #(.WIDTH(WIDTH)) bus();

  divider_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  int m_a_dly = 0;
  int m_b_dly = 0;
  int m_lat   = 2;
  bit m_early = 1'b0;
  logic prev_ack = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          a_dly;
    int          b_dly;
    int          lat;
    bit          early;
  } vec_t;
  vec_t vecs[6];
  logic [31:0] wrap_b[9];
  logic [31:0] wrap_z[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Stand-in for the divider: known quotient pairs, 0xDEADBEEF for anything else
  function automatic logic [31:0] rom(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h41100000 && b == 32'h40400000) return 32'h40400000;
    if (a == 32'h3F800000 && b[22:0] == 23'd0 && !b[31] && b[30:23] >= 8'd127 && b[30:23] <= 8'd135)
      return 32'h3F800000 - {1'b0, b[30:23] - 8'd127, 23'd0};
    return 32'hDEADBEEF;
  endfunction

  initial begin
    int ms = 0;
    int cnt = 0;
    logic [31:0] a_v = '0;
    logic [31:0] b_v = '0;
    bus.div_a_ack = 1'b0;
    bus.div_b_ack = 1'b0;
    bus.div_z_stb = 1'b0;
    bus.div_z     = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        ms = 0; cnt = 0;
        bus.div_a_ack = 1'b0; bus.div_b_ack = 1'b0; bus.div_z_stb = 1'b0;
        continue;
      end
      if (ms == 0) begin
        bus.div_a_ack = m_early;
        if (bus.div_a_stb) begin
          if (m_early || cnt >= m_a_dly) begin bus.div_a_ack = 1'b1; ms = 1; cnt = 0; end
          else cnt++;
        end
      end else if (ms == 1) begin
        a_v = bus.div_a; bus.div_a_ack = m_early; ms = 2;
      end
      if (ms == 2) begin
        bus.div_b_ack = m_early;
        if (bus.div_b_stb) begin
          if (m_early || cnt >= m_b_dly) begin bus.div_b_ack = 1'b1; ms = 3; cnt = 0; end
          else cnt++;
        end
      end else if (ms == 3) begin
        b_v = bus.div_b; bus.div_b_ack = m_early; ms = 4;
      end
      if (ms == 4) begin
        if (cnt >= m_lat) begin bus.div_z = rom(a_v, b_v); bus.div_z_stb = 1'b1; ms = 5; cnt = 0; end
        else cnt++;
      end else if (ms == 5) begin
        if (bus.div_z_ack) begin bus.div_z_stb = 1'b0; ms = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (busy) check("in_ready_low_while_busy", bus.in_ready, 1'b0);
      if (bus.div_z_ack) begin
        check("z_ack_one_cycle", prev_ack, 1'b0);
        check("out_valid_after_write", bus.out_valid, 1'b1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pop: got %h with nothing expected", bus.out_z);
        end else begin
          check("pop_value", bus.out_z, exp_q.pop_front());
        end
      end
    end
    prev_ack = bus.div_z_ack;
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    int w = 0;
    @(posedge clk); #1;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      fail_timeout("accept");
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(z);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("accept_latency_a_stb", bus.div_a_stb, 1'b1);
    check("busy_after_accept", busy, 1'b1);
    check("div_a_operand", bus.div_a, a);
    check("div_b_operand", bus.div_b, b);
    if (m_early) begin
      @(negedge clk);
      check("early_ack_b_stb", bus.div_b_stb, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (busy && w < 200) begin @(negedge clk); w++; end
    if (busy) fail_timeout("wait_idle");
  endtask

  task automatic drain();
    int w = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (count != 0 && w < 50) begin @(negedge clk); w++; end
    check("drain_count_zero", count, 0);
    check("drain_all_results_seen", exp_q.size(), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int w;
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 3, 1'b0};
    vecs[1] = '{32'h3F800000, 32'h40800000, 32'h3E800000, 2, 1, 0, 1'b0};
    vecs[2] = '{32'h41100000, 32'h40400000, 32'h40400000, 0, 0, 5, 1'b1};
    vecs[3] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3, 3, 1, 1'b0};
    vecs[4] = '{32'h3F800000, 32'h43800000, 32'h3B800000, 0, 0, 0, 1'b1};
    vecs[5] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1, 0, 7, 1'b0};
    wrap_b = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000,
               32'h42000000, 32'h42800000, 32'h43000000, 32'h43800000};
    wrap_z = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000,
               32'h3D000000, 32'h3C800000, 32'h3C000000, 32'h3B800000};

    bus.in_a = '0; bus.in_b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_stb", bus.div_a_stb, 0);
    check("rst_b_stb", bus.div_b_stb, 0);
    check("rst_z_ack", bus.div_z_ack, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_z", bus.out_z, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_count", count, 0);
    check("rst_div_a", bus.div_a, 0);
    check("rst_div_b", bus.div_b, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    // Table: single operations with consumer ready
    for (int i = 0; i < 6; i++) begin
      m_a_dly = vecs[i].a_dly; m_b_dly = vecs[i].b_dly;
      m_lat = vecs[i].lat; m_early = vecs[i].early;
      bus.out_ready = 1'b1;
      do_op(vecs[i].a, vecs[i].b, vecs[i].z);
      wait_idle();
      check("vec_count_back_to_zero", count, 0);
      $display("[TB] vector %0d: %h / %h done", i, vecs[i].a, vecs[i].b);
    end
    m_early = 1'b0; m_a_dly = 1; m_b_dly = 2; m_lat = 3;

    // Back-to-back into the FIFO, then drained in order
    bus.out_ready = 1'b0;
    do_op(32'h3F800000, 32'h40800000, 32'h3E800000);
    wait_idle();
    do_op(32'h41100000, 32'h40400000, 32'h40400000);
    wait_idle();
    check("b2b_count", count, 2);
    drain();

    // Backpressure: fill, then a held request must wait for one pop
    m_a_dly = 0; m_b_dly = 0; m_lat = 2;
    for (int i = 0; i < DEPTH; i++) begin
      do_op(32'h40C00000, 32'h40000000, 32'h40400000);
      wait_idle();
    end
    check("full_count", count, DEPTH);
    check("full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.in_a = 32'h40C00000; bus.in_b = 32'h40000000; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_not_accepted", busy, 0);
      check("full_count_held", count, DEPTH);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("after_pop_count", count, DEPTH - 1);
    do_op(32'h40C00000, 32'h40000000, 32'h40400000);
    wait_idle();
    check("refill_count", count, DEPTH);
    drain();

    // Simultaneous push and pop with count = 2
    do_op(32'h3F800000, 32'h3F800000, 32'h3F800000);
    wait_idle();
    do_op(32'h3F800000, 32'h40000000, 32'h3F000000);
    wait_idle();
    check("pp_setup_count", count, 2);
    do_op(32'h3F800000, 32'h40800000, 32'h3E800000);
    w = 0;
    while (!(bus.div_z_stb && !bus.div_z_ack) && w < 50) begin @(negedge clk); w++; end
    if (!(bus.div_z_stb && !bus.div_z_ack)) fail_timeout("pp_wait_z");
    #1;
    bus.out_ready = 1'b1;
    check("pp_pop_value", bus.out_z, exp_q.pop_front());
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("pp_count_unchanged", count, 2);
    check("pp_head_advanced", bus.out_z, 32'h3F000000);
    wait_idle();
    drain();

    // Pointer wrap: 2*DEPTH+1 distinct results
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      bus.out_ready = (k % 3 != 2);
      do_op(32'h3F800000, wrap_b[k], wrap_z[k]);
      wait_idle();
    end
    drain();

    // Reset during WAIT_Z with a result already queued
    m_lat = 10;
    do_op(32'h40C00000, 32'h40000000, 32'h40400000);
    wait_idle();
    check("mid_rst_setup_count", count, 1);
    do_op(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (6) @(negedge clk);
    check("mid_rst_busy_before", busy, 1);
    check("mid_rst_b_stb_before", bus.div_b_stb, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_a_stb", bus.div_a_stb, 0);
    check("mid_rst_b_stb", bus.div_b_stb, 0);
    check("mid_rst_z_ack", bus.div_z_ack, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    m_lat = 2;
    bus.out_ready = 1'b1;
    do_op(32'h40C00000, 32'h40000000, 32'h40400000);
    wait_idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/divider_op_sequencer.md
# divider_op_sequencer

Hardware initiator for the `divider_newton` stb/ack operand protocol. It accepts operand pairs from an upstream valid/ready stream and drives `input_a` and `input_b` into the divider one handshake at a time. It acknowledges `output_z` and buffers results in a small FIFO for a downstream valid/ready consumer. It lets on-chip logic run back-to-back IEEE-754 single-precision divisions without a testbench driving the handshake.

## Interface
- `WIDTH`, default 32: operand/result width (IEEE-754 single).
- `DEPTH`, default 4: result FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset; sampled on rising edge of `clk`.
- `in_a` in WIDTH: dividend.
- `in_b` in WIDTH: divisor.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer accepts pair this cycle.
- `div_a` out WIDTH: to divider `input_a`.
- `div_a_stb` out 1: to `input_a_stb`.
- `div_a_ack` in 1: from `input_a_ack`.
- `div_b` out WIDTH: to `input_b`.
- `div_b_stb` out 1: to `input_b_stb`.
- `div_b_ack` in 1: from `input_b_ack`.
- `div_z` in WIDTH: from `output_z`.
- `div_z_stb` in 1: from `output_z_stb`.
- `div_z_ack` out 1: to `output_z_ack`.
- `out_z` out WIDTH: FIFO head quotient.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer takes head.
- `busy` out 1: state ≠ IDLE.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z.
- **IDLE:**
  - `in_ready = (count < DEPTH)`.
  - On `in_valid && in_ready`: register `in_a`→`div_a` and `in_b`→`div_b`, then go to SEND_A.
- **SEND_A:**
  - `div_a_stb = 1`.
  - A transfer occurs on the edge where `div_a_stb && div_a_ack`; then go to SEND_B.
  - `div_a_stb` is registered and is low the next cycle.
- **SEND_B:** same as SEND_A using `div_b_stb`/`div_b_ack`; then go to WAIT_Z.
- **WAIT_Z:**
  - On `div_z_stb`: push `div_z` into the FIFO, set `div_z_ack = 1` (registered), and go to ACK_Z.
- **ACK_Z:**
  - `div_z_ack` stays high for exactly this one cycle, then goes low.
  - Go to IDLE.
  - `div_z_stb` is ignored in this state.
- The FIFO cannot overflow:
  - A new operation is accepted only when `count < DEPTH`.
  - At most one operation is in flight.
  - Therefore the push in WAIT_Z always finds room.
- FIFO behaviour:
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave `count` unchanged; the head advances.
  - Read/write pointers wrap modulo DEPTH.
- Operand and result bits pass through unmodified. The sequencer does no arithmetic.
- Stb signals never depend combinationally on acks. All handshake outputs are registered.

## Timing
- **Reset values** (`rst == 0` at edge):
  - State = IDLE.
  - `div_a_stb = div_b_stb = div_z_ack = 0`.
  - `div_a = div_b = 0`.
  - FIFO pointers and `count` = 0.
  - `out_valid = 0`, `out_z = 0`, `busy = 0`, `in_ready = 0` while in reset.
- **Reset mid-operation:** everything returns to the reset values at the next edge and any in-flight result is discarded. The integration resets the divider in the same cycle.
- **Accept latency:** pair accepted at edge T → `div_a_stb` high from T+1.
- **Handshake minimums:**
  - A-ack at edge T+k → `div_b_stb` high from T+k+1.
  - B-ack plus divider latency L → `div_z_stb` seen at edge E → FIFO write and `div_z_ack` high from E+1 to E+2.
  - `out_valid` high from E+1.
- **Throughput:** one operation per (L + 5 + handshake waits) cycles. The next `in_ready` asserts in the cycle after ACK_Z.
- `div_a` and `div_b` are held stable from accept until the next accept.
- **Acks high early:** if `div_a_ack` is already high when SEND_A is entered, the transfer completes in one cycle.

## Test plan
- **Single op:** `in_a = 0x40C00000`, `in_b = 0x40000000` (6.0/2.0), consumer ready → `out_z = 0x40400000`, `out_valid` for one cycle, `count` returns to 0, `div_z_ack` is a one-cycle pulse.
- **Back-to-back:** 1.0/4.0 (`0x3F800000`/`0x40800000`), then 9.0/3.0 (`0x41100000`/`0x40400000`) → FIFO order `0x3E800000`, then `0x40400000`. `in_ready` stays low throughout each operation.
- **Backpressure:** `out_ready = 0`, issue DEPTH ops with pair 6.0/2.0 → `count = DEPTH` and `in_ready = 0`. A fifth `in_valid` is not accepted until one pop. Popped values are all `0x40400000`.
- **Simultaneous push/pop:**
  - Setup: `count = 2`, `out_ready = 1` on the cycle of the FIFO write.
  - Expected: `count` stays at 2 and the head advances.
- **Pointer wrap:** 2·DEPTH+1 ops with distinct 1.0/n operands → results emerge in order with no loss or duplication.
- **Reset mid-op:**
  - Stimulus: drive `rst = 0` for one cycle during WAIT_Z.
  - Expected: all stb/ack outputs 0 at the next edge, `count = 0`, `out_valid = 0`.
  - A subsequent 6.0/2.0 completes to `0x40400000`.
